// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared constants, reset values and FSM encoding for the SPI command controller.
// Rev 1.0
`default_nettype none

package spi_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] RESP_HDR  = 8'h5A;

  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_READ     = 8'h02;
  localparam logic [7:0] CMD_CLEAR    = 8'h03;
  localparam logic [7:0] CMD_DEFAULTS = 8'h04;

  localparam logic [7:0] ADDR_RATE = 8'h00;
  localparam logic [7:0] ADDR_BPM  = 8'h01;
  localparam logic [7:0] ADDR_RR   = 8'h02;
  localparam logic [7:0] ADDR_CTRL = 8'h03;

  localparam int ST_CHK_ERR  = 0;
  localparam int ST_BAD_CMD  = 1;
  localparam int ST_BAD_ADDR = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_LINK_OK  = 4;

  localparam logic [15:0] RST_RATE_THR   = 16'h0100;
  localparam logic [7:0]  RST_BPM_HI     = 8'd120;
  localparam logic [7:0]  RST_BPM_LO     = 8'd50;
  localparam logic [5:0]  RST_RR_HI      = 6'd30;
  localparam logic [5:0]  RST_RR_LO      = 6'd8;
  localparam logic        RST_MONITOR_EN = 1'b1;
  localparam logic        RST_PM_MASK    = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // XOR of the seven header/payload bytes [63:8].
  function automatic logic [7:0] frame_chk(input logic [63:0] f);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 1; i < 8; i++) acc = acc ^ f[i*8 +: 8];
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_wdog.sv
// spi_cmd_wdog: link watchdog; link_ok drops after TIMEOUT_CYCLES cycles without a kick.
// Rev 1.0
`default_nettype none

module spi_cmd_wdog #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic link_ok
);

  logic [23:0] cnt;

  // A kick wins over a simultaneous expiry so the link never glitches low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 24'd0;
      link_ok <= 1'b0;
    end else if (kick) begin
      cnt     <= 24'd0;
      link_ok <= 1'b1;
    end else if (cnt >= TIMEOUT_CYCLES - 24'd1) begin
      link_ok <= 1'b0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes 64-bit SPI command frames into config registers and builds the response word.
// Optional checksum enforcement via macro SPI_CMD_CHKSUM_EN.  Rev 1.0
`default_nettype none

module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [63:0] frame_data,
  output logic [15:0] rate_thr,
  output logic [7:0]  bpm_hi,
  output logic [7:0]  bpm_lo,
  output logic [5:0]  rr_hi,
  output logic [5:0]  rr_lo,
  output logic        monitor_en,
  output logic        pm_mask,
  output logic        clr_flags,
  output logic [63:0] resp_word,
  output logic        link_ok,
  output logic [7:0]  err_cnt
);

  state_t      state;
  logic [63:0] frame;
  logic [2:0]  err_stat;
  logic        ovr_pend;
  logic [7:0]  seq;

  logic        chk_err, bad_cmd, bad_addr, reject, drop, kick;
  logic [7:0]  cmd, addr;
  logic [31:0] rd_mux;
  logic [7:0]  status;
  logic [8:0]  err_sum;
  logic [7:0]  err_next;
  logic        unused_frame;

  assign cmd  = frame[55:48];
  assign addr = frame[47:40];
  assign unused_frame = ^{frame[39:24], frame[7:0]};

  always_comb begin
    chk_err = (frame[63:56] != SYNC_BYTE);
`ifdef SPI_CMD_CHKSUM_EN
    chk_err = chk_err | (frame[7:0] != frame_chk(frame));
`endif
    bad_cmd  = !chk_err && (cmd > CMD_DEFAULTS);
    bad_addr = !chk_err && !bad_cmd && ((cmd == CMD_WRITE) || (cmd == CMD_READ))
               && (addr > ADDR_CTRL);
    reject   = chk_err | bad_cmd | bad_addr;
    drop     = frame_valid && (state != S_IDLE);
    kick     = (state == S_CHECK) && !reject;

    case (addr)
      ADDR_RATE: rd_mux = {16'h0000, rate_thr};
      ADDR_BPM:  rd_mux = {16'h0000, bpm_hi, bpm_lo};
      ADDR_RR:   rd_mux = {20'h00000, rr_hi, rr_lo};
      ADDR_CTRL: rd_mux = {30'h0, pm_mask, monitor_en};
      default:   rd_mux = 32'h0;
    endcase

    // A drop in the very cycle a response is built is reported in that response.
    status              = 8'h00;
    status[ST_CHK_ERR]  = err_stat[0];
    status[ST_BAD_CMD]  = err_stat[1];
    status[ST_BAD_ADDR] = err_stat[2];
    status[ST_OVERRUN]  = ovr_pend | drop;
    status[ST_LINK_OK]  = link_ok;

    err_sum  = {1'b0, err_cnt} + {8'd0, (state == S_CHECK) && reject} + {8'd0, drop};
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      frame      <= 64'h0;
      err_stat   <= 3'b000;
      ovr_pend   <= 1'b0;
      seq        <= 8'h00;
      err_cnt    <= 8'h00;
      rate_thr   <= RST_RATE_THR;
      bpm_hi     <= RST_BPM_HI;
      bpm_lo     <= RST_BPM_LO;
      rr_hi      <= RST_RR_HI;
      rr_lo      <= RST_RR_LO;
      monitor_en <= RST_MONITOR_EN;
      pm_mask    <= RST_PM_MASK;
      clr_flags  <= 1'b0;
      resp_word  <= 64'h0;
    end else begin
      clr_flags <= 1'b0;
      err_cnt   <= err_next;
      if (drop) ovr_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (frame_valid) begin
            frame <= frame_data;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_stat <= {bad_addr, bad_cmd, chk_err};
          if (reject) begin
            state <= S_RESP;
          end else begin
            seq   <= seq + 8'd1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cmd)
            CMD_WRITE: begin
              case (addr)
                ADDR_RATE: rate_thr            <= frame[23:8];
                ADDR_BPM:  {bpm_hi, bpm_lo}    <= frame[23:8];
                ADDR_RR:   {rr_hi, rr_lo}      <= frame[19:8];
                ADDR_CTRL: {pm_mask, monitor_en} <= frame[9:8];
                default: ;
              endcase
            end
            CMD_CLEAR: clr_flags <= 1'b1;
            CMD_DEFAULTS: begin
              rate_thr   <= RST_RATE_THR;
              bpm_hi     <= RST_BPM_HI;
              bpm_lo     <= RST_BPM_LO;
              rr_hi      <= RST_RR_HI;
              rr_lo      <= RST_RR_LO;
              monitor_en <= RST_MONITOR_EN;
              pm_mask    <= RST_PM_MASK;
            end
            default: ;
          endcase
          resp_word <= {RESP_HDR, cmd, status, (cmd == CMD_READ) ? rd_mux : 32'h0, seq};
          ovr_pend  <= 1'b0;
          state     <= S_RESP;
        end
        S_RESP: begin
          // Rejected frames skip EXEC, so their response is built here, still at N+3.
          if (err_stat != 3'b000) begin
            resp_word <= {RESP_HDR, cmd, status, 32'h0, seq};
            ovr_pend  <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  spi_cmd_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .kick   (kick),
    .link_ok(link_ok)
  );

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: scoreboard bench for spi_cmd_ctrl (watchdog timeout shortened to 16 cycles).
`default_nettype none

module tb_spi_cmd_ctrl;
  import spi_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [63:0] frame_data = 64'h0;
  logic [15:0] rate_thr;
  logic [7:0]  bpm_hi, bpm_lo, err_cnt;
  logic [5:0]  rr_hi, rr_lo;
  logic        monitor_en, pm_mask, clr_flags, link_ok;
  logic [63:0] resp_word;

  spi_cmd_ctrl #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .rate_thr(rate_thr), .bpm_hi(bpm_hi), .bpm_lo(bpm_lo), .rr_hi(rr_hi), .rr_lo(rr_lo),
    .monitor_en(monitor_en), .pm_mask(pm_mask), .clr_flags(clr_flags),
    .resp_word(resp_word), .link_ok(link_ok), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rise_cyc = 0, fall_cyc = 0, clr_cnt = 0;
  logic prev_link = 1'b0;
  always @(negedge clk) begin
    prev_link <= link_ok;
    if (link_ok && !prev_link) rise_cyc <= cyc;
    if (!link_ok && prev_link) fall_cyc <= cyc;
    if (clr_flags) clr_cnt <= clr_cnt + 1;
  end

  int checks = 0, failures = 0;

  typedef struct {
    int          due;
    logic [63:0] resp;
    logic [45:0] cfg;
    logic        clr;
    logic [7:0]  err;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [15:0] m_rate;
  logic [7:0]  m_bh, m_bl, m_seq, m_err;
  logic [5:0]  m_rh, m_rl;
  logic        m_me, m_pm;

  function automatic void model_defaults();
    m_rate = 16'h0100; m_bh = 8'd120; m_bl = 8'd50; m_rh = 6'd30; m_rl = 6'd8;
    m_me = 1'b1; m_pm = 1'b0;
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] sync, input logic [7:0] cmd,
                                     input logic [7:0] addr, input logic [31:0] pl,
                                     input logic corrupt);
    logic [55:0] h;
    logic [7:0]  c;
    h = {sync, cmd, addr, pl};
    c = h[55:48] ^ h[47:40] ^ h[39:32] ^ h[31:24] ^ h[23:16] ^ h[15:8] ^ h[7:0];
    if (corrupt) c = c ^ 8'h3C;
    return {h, c};
  endfunction

  function automatic exp_t model(input logic [63:0] f, input logic ovr, input logic link);
    exp_t        e;
    logic [7:0]  cmd, addr;
    logic [31:0] pl, rd;
    logic        ce, bc, ba, lk;
    int          s;
    cmd = f[55:48]; addr = f[47:40]; pl = f[39:8]; rd = 32'h0; lk = link;
    e.clr = 1'b0;
    ce = (f[63:56] != 8'hA5);
`ifdef SPI_CMD_CHKSUM_EN
    ce = ce | (f[7:0] != (f[63:56] ^ f[55:48] ^ f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8]));
`endif
    bc = !ce && (cmd > 8'h04);
    ba = !ce && !bc && (cmd == 8'h01 || cmd == 8'h02) && (addr > 8'h03);
    if (!(ce | bc | ba)) begin
      m_seq = m_seq + 8'd1;
      lk = 1'b1;
      case (cmd)
        8'h01: case (addr)
          8'h00: m_rate = pl[15:0];
          8'h01: {m_bh, m_bl} = pl[15:0];
          8'h02: {m_rh, m_rl} = pl[11:0];
          default: {m_pm, m_me} = pl[1:0];
        endcase
        8'h02: case (addr)
          8'h00: rd = {16'h0, m_rate};
          8'h01: rd = {16'h0, m_bh, m_bl};
          8'h02: rd = {20'h0, m_rh, m_rl};
          default: rd = {30'h0, m_pm, m_me};
        endcase
        8'h03: e.clr = 1'b1;
        8'h04: model_defaults();
        default: ;
      endcase
    end
    s = int'(m_err) + int'(ce | bc | ba) + int'(ovr);
    m_err = (s > 255) ? 8'hFF : s[7:0];
    e.resp = {8'h5A, cmd, {3'b000, lk, ovr, ba, bc, ce}, rd, m_seq};
    e.cfg  = {m_rate, m_bh, m_bl, m_rh, m_rl, m_me, m_pm};
    e.err  = m_err;
    e.due  = 0;
    return e;
  endfunction

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if (e.due != cyc) begin
          failures++;
          $display("FAIL sb_timing: response checked at cycle %0d, required %0d", cyc, e.due);
        end
        checks++;
        if (resp_word !== e.resp) begin
          failures++;
          $display("FAIL resp_word: got %h expected %h", resp_word, e.resp);
        end
        checks++;
        if ({rate_thr, bpm_hi, bpm_lo, rr_hi, rr_lo, monitor_en, pm_mask} !== e.cfg) begin
          failures++;
          $display("FAIL config: got %h expected %h",
                   {rate_thr, bpm_hi, bpm_lo, rr_hi, rr_lo, monitor_en, pm_mask}, e.cfg);
        end
        checks++;
        if (clr_flags !== e.clr) begin
          failures++;
          $display("FAIL clr_flags: got %b expected %b", clr_flags, e.clr);
        end
        checks++;
        if (err_cnt !== e.err) begin
          failures++;
          $display("FAIL err_cnt: got %0d expected %0d", err_cnt, e.err);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_defaults(); m_seq = 8'h00; m_err = 8'h00;
    sbq.delete();
  endtask

  task automatic send(input logic [63:0] f, input logic link);
    exp_t e;
    @(posedge clk); #1;
    frame_valid = 1'b1; frame_data = f;
    e = model(f, 1'b0, link);
    e.due = cyc + 3;
    sbq.push_back(e);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({rate_thr, bpm_hi, bpm_lo, rr_hi, rr_lo, monitor_en, pm_mask} !==
        {16'h0100, 8'd120, 8'd50, 6'd30, 6'd8, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_config: got %h %h %h %h %h %b %b", rate_thr, bpm_hi, bpm_lo,
               rr_hi, rr_lo, monitor_en, pm_mask);
    end
    checks++;
    if (resp_word !== 64'h0) begin
      failures++; $display("FAIL reset_resp: got %h expected 0", resp_word);
    end
    checks++;
    if ({clr_flags, link_ok, err_cnt} !== 10'h0) begin
      failures++;
      $display("FAIL reset_flags: clr=%b link=%b err=%0d expected all 0", clr_flags, link_ok, err_cnt);
    end
  endtask

  task automatic test_write_bpm();
    send(mk(8'hA5, 8'h01, 8'h01, 32'h0000_7832, 1'b0), 1'b1);
    checks++;
    if (resp_word[47:40] !== 8'h10 || resp_word[7:0] !== 8'h01) begin
      failures++;
      $display("FAIL write_bpm_status: status=%h seq=%h required 10/01", resp_word[47:40], resp_word[7:0]);
    end
  endtask

  task automatic test_read_default();
    do_reset();
    send(mk(8'hA5, 8'h02, 8'h00, 32'h0, 1'b0), 1'b1);
    send(mk(8'hA5, 8'h01, 8'h02, 32'hFFFF_F5A7, 1'b0), 1'b1);
    send(mk(8'hA5, 8'h02, 8'h02, 32'h0, 1'b0), 1'b1);
    send(mk(8'hA5, 8'h02, 8'h03, 32'h0, 1'b0), 1'b1);
  endtask

  task automatic test_errors();
    do_reset();
    send(mk(8'hA4, 8'h01, 8'h00, 32'h1111, 1'b0), 1'b0);
    send(mk(8'hA5, 8'h07, 8'h00, 32'h0, 1'b0), 1'b0);
    send(mk(8'hA5, 8'h01, 8'h05, 32'h2222, 1'b0), 1'b0);
    send(mk(8'hA5, 8'h02, 8'h09, 32'h0, 1'b0), 1'b0);
    for (int i = 0; i < 256; i++) send(mk(8'h00, 8'h00, 8'h00, 32'h0, 1'b0), 1'b0);
  endtask

  task automatic test_chksum();
    do_reset();
    send(mk(8'hA5, 8'h01, 8'h00, 32'h0000_1234, 1'b1), 1'b0);
    send(mk(8'hA5, 8'h02, 8'h00, 32'h0, 1'b0), 1'b1);
  endtask

  task automatic test_clear();
    int c0;
    c0 = clr_cnt;
    send(mk(8'hA5, 8'h03, 8'h00, 32'h0, 1'b0), 1'b1);
    repeat (2) @(posedge clk);
    checks++;
    if (clr_cnt - c0 !== 1) begin
      failures++; $display("FAIL clr_pulse_width: got %0d cycles expected 1", clr_cnt - c0);
    end
  endtask

  task automatic test_defaults();
    send(mk(8'hA5, 8'h01, 8'h00, 32'h0000_BEEF, 1'b0), 1'b1);
    send(mk(8'hA5, 8'h01, 8'h03, 32'h0000_0002, 1'b0), 1'b1);
    send(mk(8'hA5, 8'h04, 8'h00, 32'h0, 1'b0), 1'b1);
    send(mk(8'hA5, 8'h02, 8'h03, 32'h0, 1'b0), 1'b1);
  endtask

  task automatic test_overrun();
    exp_t e;
    logic [63:0] fa;
    do_reset();
    fa = mk(8'hA5, 8'h01, 8'h00, 32'h0000_0055, 1'b0);
    @(posedge clk); #1;
    frame_valid = 1'b1; frame_data = fa;
    e = model(fa, 1'b1, 1'b1);
    e.due = cyc + 3;
    sbq.push_back(e);
    @(posedge clk); #1;
    frame_data = mk(8'hA5, 8'h01, 8'h00, 32'h0000_0099, 1'b0);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    repeat (5) @(posedge clk);
    send(mk(8'hA5, 8'h02, 8'h00, 32'h0, 1'b0), 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 260; i++) send(mk(8'hA5, 8'h00, i[7:0], 32'h0, 1'b0), 1'b1);
  endtask

  task automatic test_watchdog();
    int i;
    do_reset();
    send(mk(8'hA5, 8'h00, 8'h00, 32'h0, 1'b0), 1'b1);
    i = 0;
    while (link_ok && i < 40) begin @(negedge clk); i++; end
    @(posedge clk);
    checks++;
    if (link_ok !== 1'b0) begin
      failures++; $display("FAIL wdog_expire: link_ok=%b after 40 cycles expected 0", link_ok);
    end
    checks++;
    if (fall_cyc - rise_cyc !== 16) begin
      failures++; $display("FAIL wdog_period: link_ok high %0d cycles expected 16", fall_cyc - rise_cyc);
    end
    send(mk(8'hA4, 8'h00, 8'h00, 32'h0, 1'b0), 1'b0);
    send(mk(8'hA5, 8'h00, 8'h00, 32'h0, 1'b0), 1'b1);
    checks++;
    if (link_ok !== 1'b1) begin
      failures++; $display("FAIL wdog_restore: link_ok=%b expected 1", link_ok);
    end
  endtask

  task automatic test_rst_exec();
    int c0;
    do_reset();
    c0 = clr_cnt;
    @(posedge clk); #1;
    frame_valid = 1'b1; frame_data = mk(8'hA5, 8'h01, 8'h00, 32'h0000_ABCD, 1'b0);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.state !== S_EXEC) begin
      failures++; $display("FAIL rst_exec_state_pre: got %0d expected %0d", dut.state, S_EXEC);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dut.state !== S_IDLE || rate_thr !== 16'h0100) begin
      failures++;
      $display("FAIL rst_exec: state=%0d rate_thr=%h expected %0d/0100", dut.state, rate_thr, S_IDLE);
    end
    repeat (4) @(posedge clk);
    checks++;
    if (clr_cnt != c0 || resp_word !== 64'h0 || rate_thr !== 16'h0100) begin
      failures++;
      $display("FAIL rst_exec_after: clr_pulses=%0d resp=%h rate=%h expected 0/0/0100",
               clr_cnt - c0, resp_word, rate_thr);
    end
    model_defaults(); m_seq = 8'h00; m_err = 8'h00;
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    do_reset();
    test_reset();
    test_write_bpm();
    test_read_default();
    test_errors();
    test_chksum();
    test_clear();
    test_defaults();
    test_overrun();
    test_back_to_back();
    test_watchdog();
    test_rst_exec();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL sb_drain: %0d responses never seen, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
